// File: rtl/led_seq_mboot.sv
// led_seq_mboot: LED pattern sequencer with a debounced multiboot reboot request.
// Patterns (rotate / bounce / blink / off) advance once per PERIOD clocks. A debounced
// button press latches boot_addr onto dynamic_addr and then drives rebootn low for
// REBOOT_LOW_CYCLES clocks. Defining LED_DIM_EN adds a 16-step PWM dimmer on LED.
module led_seq_mboot #(
    parameter int N_LED             = 3,
    parameter int PERIOD            = 24000000,
    parameter int DEB_CYCLES        = 240000,
    parameter int REBOOT_LOW_CYCLES = 16,
    parameter int DUTY              = 8
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic [1:0]       mode,
    input  logic             key_n,
    input  logic [7:0]       boot_addr,
    output logic [N_LED-1:0] LED,
    output logic             tick,
    output logic             rebootn,
    output logic [7:0]       dynamic_addr
);

    localparam int PW = $clog2(PERIOD);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int RW = $clog2(REBOOT_LOW_CYCLES + 1);

    localparam logic [N_LED-1:0] PAT_ONE   = {{(N_LED-1){1'b0}}, 1'b1};
    localparam logic [N_LED-1:0] PAT_ONES  = {N_LED{1'b1}};
    localparam logic [N_LED-1:0] PAT_ZEROS = {N_LED{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARM   = 2'b01,
        ST_PULSE = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

    logic [1:0]       mode_q_r;
    logic [PW-1:0]    pre_cnt_r;
    logic             tick_r;
    logic [N_LED-1:0] pat_r;
    logic             dir_up_r;
    logic             step_s;
    logic [N_LED-1:0] pat_nxt_s;
    logic             dir_nxt_s;

    logic             sync1_r;
    logic             sync2_r;
    logic             key_db_r;
    logic             key_db_d_r;
    logic [DW-1:0]    deb_cnt_r;
    logic             key_fall_s;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [RW-1:0]    pulse_cnt_r;
    logic             rebootn_nxt_s;
    logic             addr_load_s;
    logic             rebootn_r;
    logic [7:0]       dyn_addr_r;

    assign step_s     = (pre_cnt_r == PW'(PERIOD - 1));
    assign key_fall_s = key_db_d_r & ~key_db_r;

    // Next pattern and direction for one step of the current mode.
    always_comb begin
        pat_nxt_s = pat_r;
        dir_nxt_s = dir_up_r;
        case (mode_q_r)
            2'b00: pat_nxt_s = {pat_r[N_LED-2:0], pat_r[N_LED-1]};
            2'b01: begin
                if (dir_up_r) begin
                    pat_nxt_s = {pat_r[N_LED-2:0], 1'b0};
                    dir_nxt_s = ~pat_r[N_LED-2];
                end else begin
                    pat_nxt_s = {1'b0, pat_r[N_LED-1:1]};
                    dir_nxt_s = pat_r[1];
                end
            end
            2'b10: begin
                if (pat_r == PAT_ONES) begin
                    pat_nxt_s = PAT_ZEROS;
                end else begin
                    pat_nxt_s = PAT_ONES;
                end
            end
            2'b11:   pat_nxt_s = PAT_ZEROS;
            default: pat_nxt_s = PAT_ZEROS;
        endcase
    end

    // Mode tracking, prescaler, step strobe and pattern state; a mode change restarts the step.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            mode_q_r  <= mode;
            pre_cnt_r <= {PW{1'b0}};
            tick_r    <= 1'b0;
            pat_r     <= PAT_ONE;
            dir_up_r  <= 1'b1;
        end else if (mode != mode_q_r) begin
            mode_q_r  <= mode;
            pre_cnt_r <= {PW{1'b0}};
            tick_r    <= 1'b0;
            pat_r     <= mode[1] ? PAT_ZEROS : PAT_ONE;
            dir_up_r  <= 1'b1;
        end else begin
            tick_r    <= step_s;
            pre_cnt_r <= step_s ? {PW{1'b0}} : pre_cnt_r + PW'(1);
            if (step_s) begin
                pat_r    <= pat_nxt_s;
                dir_up_r <= dir_nxt_s;
            end
        end
    end

    // Key synchroniser, stable-level debounce and one-cycle-delayed copy for edge detect.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            key_db_r   <= 1'b1;
            key_db_d_r <= 1'b1;
            deb_cnt_r  <= {DW{1'b0}};
        end else begin
            sync1_r    <= key_n;
            sync2_r    <= sync1_r;
            key_db_d_r <= key_db_r;
            if (sync2_r == key_db_r) begin
                deb_cnt_r <= {DW{1'b0}};
            end else if (deb_cnt_r == DW'(DEB_CYCLES - 1)) begin
                key_db_r  <= sync2_r;
                deb_cnt_r <= {DW{1'b0}};
            end else begin
                deb_cnt_r <= deb_cnt_r + DW'(1);
            end
        end
    end

    // Reboot FSM state register.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Length of the rebootn low pulse, counted only while in PULSE.
    always_ff @(posedge CLK_IN) begin
        if (RST || (state_r != ST_PULSE)) begin
            pulse_cnt_r <= {RW{1'b0}};
        end else begin
            pulse_cnt_r <= pulse_cnt_r + RW'(1);
        end
    end

    // Reboot FSM next-state logic: one pulse per accepted press, re-armed only after release.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (key_fall_s) begin
                    state_nxt_s = ST_ARM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARM: state_nxt_s = ST_PULSE;
            ST_PULSE: begin
                if (pulse_cnt_r == RW'(REBOOT_LOW_CYCLES - 1)) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_PULSE;
                end
            end
            ST_HOLD: begin
                if (key_db_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Reboot FSM output decode from the upcoming state so the registered outputs align with it.
    always_comb begin
        rebootn_nxt_s = (state_nxt_s != ST_PULSE);
        addr_load_s   = (state_nxt_s == ST_ARM);
    end

    // Registered reboot outputs; the address is captured on entry to ARM and held until the next ARM.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            rebootn_r  <= 1'b1;
            dyn_addr_r <= 8'h00;
        end else begin
            rebootn_r <= rebootn_nxt_s;
            if (addr_load_s) begin
                dyn_addr_r <= boot_addr;
            end
        end
    end

`ifdef LED_DIM_EN
    localparam logic [4:0] DUTY_V = 5'(DUTY);
    logic [3:0] pwm_cnt_r;

    // Free-running PWM phase counter for LED dimming.
    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            pwm_cnt_r <= 4'h0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 4'h1;
        end
    end

    assign LED = pat_r & {N_LED{({1'b0, pwm_cnt_r} < DUTY_V)}};
`else
    assign LED = pat_r;
`endif

    assign tick         = tick_r;
    assign rebootn      = rebootn_r;
    assign dynamic_addr = dyn_addr_r;

endmodule

// File: tb/tb_led_seq_mboot.sv
// Testbench for led_seq_mboot: directed scenarios plus randomized stimulus, all checked
// every cycle against a behavioural model (step index, timeline and sample history).
module tb_led_seq_mboot;

    localparam int N_LED   = 3;
    localparam int PERIOD  = 4;
    localparam int DEB     = 3;
    localparam int RLC     = 4;
    localparam int DUTY_TB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       key_n;
    logic [7:0] boot_addr;
    logic [2:0] led;
    logic       tick;
    logic       rebootn;
    logic [7:0] dynamic_addr;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    led_seq_mboot #(
        .N_LED(N_LED), .PERIOD(PERIOD), .DEB_CYCLES(DEB), .REBOOT_LOW_CYCLES(RLC)
    ) dut (
        .CLK_IN(clk), .RST(rst), .mode(mode), .key_n(key_n), .boot_addr(boot_addr),
        .LED(led), .tick(tick), .rebootn(rebootn), .dynamic_addr(dynamic_addr)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         m_c;         // cycles since reset / mode entry
    int         m_k;         // steps since reset / mode entry
    bit         m_from_rst;  // current pattern run started from reset
    logic [1:0] m_mode;
    logic       m_tick;
    int         m_t;         // edges since ARM entry, -1 when idle
    logic [7:0] m_addr;
    logic       m_db;
    logic       m_db_prev;
    logic       ks[$];       // key_n samples, newest first
    int         m_pwm;

    // Model update on each active edge, from pre-edge values.
    always @(posedge clk) begin
        bit acc;
        if (rst) begin
            m_c = 0; m_k = 0; m_from_rst = 1'b1; m_mode = mode; m_tick = 1'b0;
            m_t = -1; m_addr = 8'h00; m_db = 1'b1; m_db_prev = 1'b1; m_pwm = 0;
            ks.delete();
            for (int i = 0; i < DEB + 2; i++) ks.push_back(1'b1);
        end else begin
            // reboot timeline
            if (m_t < 0) begin
                if (m_db_prev && !m_db) begin
                    m_t = 0;
                    m_addr = boot_addr;
                end
            end else if (m_t >= RLC + 1 && m_db) begin
                m_t = -1;
            end else if (m_t < RLC + 1) begin
                m_t++;
            end
            // debounce: accept after DEB consecutive synced samples opposite to current level
            acc = 1'b1;
            for (int i = 1; i <= DEB; i++) if (ks[i] == m_db) acc = 1'b0;
            m_db_prev = m_db;
            if (acc) m_db = ks[1];
            ks.push_front(key_n);
            void'(ks.pop_back());
            // pattern timing
            if (mode != m_mode) begin
                m_mode = mode; m_c = 0; m_k = 0; m_tick = 1'b0; m_from_rst = 1'b0;
            end else begin
                m_c++;
                m_tick = (m_c % PERIOD == 0);
                if (m_tick) m_k++;
            end
            m_pwm = (m_pwm + 1) % 16;
        end
    end

    function automatic logic [2:0] dimmed(input logic [2:0] v);
`ifdef LED_DIM_EN
        return (m_pwm < DUTY_TB) ? v : 3'b000;
`else
        return v;
`endif
    endfunction

    function automatic logic [2:0] exp_led();
        logic [2:0] v;
        int p;
        if (m_from_rst && m_k == 0) begin
            v = 3'b001;
        end else begin
            case (m_mode)
                2'b00: v = 3'b001 << (m_k % N_LED);
                2'b01: begin
                    p = m_k % (2 * (N_LED - 1));
                    if (p >= N_LED) p = 2 * (N_LED - 1) - p;
                    v = 3'b001 << p;
                end
                2'b10:   v = (m_k == 0) ? 3'b000 : ((m_k % 2 == 1) ? 3'b111 : 3'b000);
                default: v = 3'b000;
            endcase
        end
        return dimmed(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("led", 32'(led), 32'(exp_led()));
            check("tick", 32'(tick), 32'(m_tick));
            check("rebootn", 32'(rebootn), 32'((m_t >= 1 && m_t <= RLC) ? 1'b0 : 1'b1));
            check("dynamic_addr", 32'(dynamic_addr), 32'(m_addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int budget);
        int n = 0;
        do begin step(1); n++; end while (tick !== 1'b1 && n < budget);
        if (tick !== 1'b1) check("tick_timeout", 32'(tick), 32'd1);
    endtask

    // Hold key low for n cycles, counting rebootn falls and low cycles.
    task automatic press_count(input int n, output int falls, output int lows,
                               output logic [7:0] addr_before);
        logic       prev_rb;
        logic [7:0] prev_addr;
        falls = 0; lows = 0; addr_before = 8'h00;
        prev_rb = rebootn; prev_addr = dynamic_addr;
        key_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (rebootn == 1'b0) begin
                lows++;
                if (prev_rb == 1'b1) begin
                    falls++;
                    addr_before = prev_addr;
                end
            end
            prev_rb = rebootn; prev_addr = dynamic_addr;
        end
        key_n = 1'b1;
    endtask

    logic [2:0] bounce_tab [8] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b010};

    initial begin
        int         ticks, falls, lows, hold;
        logic [7:0] ab;
        bit         low_seen;

        rst = 1'b1; mode = 2'b00; key_n = 1'b1; boot_addr = 8'h00;
        step(2);
        chk_en = 1'b1;
        check("rst_led", 32'(led), 32'(dimmed(3'b001)));
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_rebootn", 32'(rebootn), 32'd1);
        check("rst_addr", 32'(dynamic_addr), 32'h00);
        rst = 1'b0;

        // rotate: first tick four cycles after reset
        step(4);
        check("rot_first_tick", 32'(tick), 32'd1);
        check("rot_first_led", 32'(led), 32'(dimmed(3'b010)));
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (tick) ticks++;
        end
        check("rot_tick_count", 32'(ticks), 32'd4);

        // bounce sequence
        mode = 2'b01;
        step(1);
        check("bounce_entry", 32'(led), 32'(dimmed(bounce_tab[0])));
        for (int i = 1; i < 8; i++) begin
            wait_tick(10);
            check("bounce_step", 32'(led), 32'(dimmed(bounce_tab[i])));
        end

        // switch to blink mid-step
        step(2);
        mode = 2'b10;
        step(1);
        check("blink_entry_led", 32'(led), 32'(dimmed(3'b000)));
        check("blink_entry_tick", 32'(tick), 32'd0);
        step(4);
        check("blink_tick1", 32'(tick), 32'd1);
        check("blink_on", 32'(led), 32'(dimmed(3'b111)));
        step(4);
        check("blink_off", 32'(led), 32'(dimmed(3'b000)));

        // short glitch is ignored
        boot_addr = 8'h0A;
        key_n = 1'b0;
        step(2);
        key_n = 1'b1;
        low_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (rebootn == 1'b0) low_seen = 1'b1;
        end
        check("glitch_no_pulse", 32'(low_seen), 32'd0);
        check("glitch_addr", 32'(dynamic_addr), 32'h00);

        // long press: exactly one pulse of RLC cycles, address set beforehand
        press_count(40, falls, lows, ab);
        check("long_falls", 32'(falls), 32'd1);
        check("long_low_cycles", 32'(lows), 32'd4);
        check("long_addr_before_fall", 32'(ab), 32'h0A);
        step(20);
        boot_addr = 8'h5C;
        step(3);
        check("addr_held", 32'(dynamic_addr), 32'h0A);
        press_count(30, falls, lows, ab);
        check("second_falls", 32'(falls), 32'd1);
        check("second_low_cycles", 32'(lows), 32'd4);
        check("second_addr", 32'(dynamic_addr), 32'h5C);
        step(20);

        // reset during the second PULSE cycle
        boot_addr = 8'h33;
        key_n = 1'b0;
        hold = 0;
        do begin step(1); hold++; end while (rebootn !== 1'b0 && hold < 20);
        check("pulse_start_seen", 32'(rebootn), 32'd0);
        step(1);
        rst = 1'b1; key_n = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_rebootn", 32'(rebootn), 32'd1);
        check("midrst_addr", 32'(dynamic_addr), 32'h00);
        check("midrst_led", 32'(led), 32'(dimmed(3'b001)));
        step(10);

        // randomized phase
        hold = 5;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
            if (hold == 0) begin
                key_n = ~key_n;
                hold = key_n ? $urandom_range(1, 30) : $urandom_range(1, 12);
            end else begin
                hold--;
            end
            boot_addr = 8'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            step(1);
        end
        rst = 1'b0; key_n = 1'b1;
        step(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
